// File: rtl/fifo_reader.sv
// Pulls words from an upstream FIFO with 1-cycle read latency and delivers them downstream
// through a small skid buffer so in-flight words survive back-pressure.
module fifo_reader #(
   parameter int DATA_W = 6,
   parameter int SKID_D = 2
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic              pause,
   output logic              fifo_rd,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [7:0]        word_cnt,
   output logic              busy
);

   localparam int PTR_W = $clog2(SKID_D);
   localparam int OCC_W = $clog2(SKID_D + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SKID_D - 1);
   localparam logic [OCC_W:0]   LVL_MAX  = (OCC_W + 1)'(SKID_D);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STALL
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [OCC_W-1:0]  r_occ;
   logic              r_inflight;
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [DATA_W-1:0] r_skid [SKID_D];
   logic [DATA_W-1:0] r_dataOut;
   logic              r_validOut;
   logic [7:0]        r_wordCnt;

   logic [OCC_W:0]    w_level;
   logic              w_capture;
   logic              w_deliver;
   logic              w_bypass;
   logic              w_write;
   logic              w_read;
   logic [DATA_W-1:0] w_deliverData;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign w_level   = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_inflight};
   assign fifo_rd   = !fifo_empty && !pause && (w_level < LVL_MAX) && !RESET;

   // An arriving word goes straight to the output when the skid is empty, otherwise
   // it queues behind older words so order is preserved.
   assign w_capture     = r_inflight;
   assign w_deliver     = !pause && ((r_occ != '0) || w_capture);
   assign w_bypass      = w_deliver && (r_occ == '0);
   assign w_write       = w_capture && !w_bypass;
   assign w_read        = w_deliver && !w_bypass;
   assign w_deliverData = w_bypass ? fifo_data : r_skid[r_rdPtr];

   assign data_out  = r_dataOut;
   assign valid_out = r_validOut;
   assign word_cnt  = r_wordCnt;
   assign busy      = (r_state != IDLE);

   always_ff @(posedge clk) begin
      if (w_write) begin
         r_skid[r_wrPtr] <= fifo_data;
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_state    <= IDLE;
         r_occ      <= '0;
         r_inflight <= 1'b0;
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_dataOut  <= '0;
         r_validOut <= 1'b0;
         r_wordCnt  <= '0;
      end else begin
         r_state    <= w_nextState;
         r_inflight <= fifo_rd;
         r_validOut <= w_deliver;
         if (w_deliver) begin
            r_dataOut <= w_deliverData;
            r_wordCnt <= r_wordCnt + 8'd1;
         end
         if (w_write) begin
            r_wrPtr <= nextPtr(r_wrPtr);
         end
         if (w_read) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         case ({w_write, w_read})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (fifo_rd) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            if (pause) begin
               w_nextState = STALL;
            end else if ((r_occ == '0) && !r_inflight && fifo_empty) begin
               w_nextState = IDLE;
            end
         end
         STALL: begin
            if (!pause) begin
               w_nextState = RUN;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: an upstream FIFO model feeds the DUT and a
// queue-based reference predicts every read strobe and delivered word.
module tb_fifo_reader;

   localparam int DATA_W = 6;
   localparam int SKID_D = 2;

   logic              clk = 1'b0;
   logic              RESET;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data;
   logic              pause;
   logic              fifo_rd;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic [7:0]        word_cnt;
   logic              busy;

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] srcQ [$];
   logic [DATA_W-1:0] mHeld [$];
   logic              mInflight;
   logic [DATA_W-1:0] mInflightWord;
   logic [7:0]        mCnt;

   fifo_reader #(.DATA_W(DATA_W), .SKID_D(SKID_D)) dut (
      .clk        (clk),
      .RESET      (RESET),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .pause      (pause),
      .fifo_rd    (fifo_rd),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .word_cnt   (word_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, predict the read strobe, then predict the delivery.
   task automatic applyStimulus(input logic p, input logic fe);
      logic              rdNow;
      logic              expRd;
      logic [DATA_W-1:0] w;
      pause      = p;
      fifo_empty = fe || (srcQ.size() == 0);
      #1;
      expRd = !fifo_empty && !p && ((mHeld.size() + int'(mInflight)) < SKID_D);
      checkOutput("fifo_rd", {31'd0, fifo_rd}, {31'd0, expRd});
      checkOutput("rd_while_empty", {31'd0, fifo_rd && fifo_empty}, 32'd0);
      rdNow = fifo_rd && !fifo_empty;
      @(posedge clk);
      #1;
      if (mInflight) mHeld.push_back(mInflightWord);
      if (!p && mHeld.size() > 0) begin
         w = mHeld.pop_front();
         mCnt++;
         checkOutput("valid_out", {31'd0, valid_out}, 32'd1);
         checkOutput("data_out", {26'd0, data_out}, {26'd0, w});
      end else begin
         checkOutput("valid_out", {31'd0, valid_out}, 32'd0);
      end
      checkOutput("word_cnt", {24'd0, word_cnt}, {24'd0, mCnt});
      mInflight = 1'b0;
      if (rdNow && srcQ.size() > 0) begin
         mInflightWord = srcQ.pop_front();
         mInflight     = 1'b1;
         fifo_data     = mInflightWord;
      end
   endtask

   task automatic doReset();
      pause      = 1'b0;
      fifo_empty = (srcQ.size() == 0);
      RESET      = 1'b1;
      #1;
      checkOutput("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
      checkOutput("rst_valid", {31'd0, valid_out}, 32'd0);
      checkOutput("rst_data", {26'd0, data_out}, 32'd0);
      checkOutput("rst_cnt", {24'd0, word_cnt}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      RESET = 1'b0;
      mHeld.delete();
      mInflight = 1'b0;
      mCnt      = 8'd0;
   endtask

   task automatic drain(input int maxCycles);
      int n = 0;
      while ((srcQ.size() > 0 || mHeld.size() > 0 || mInflight) && n < maxCycles) begin
         applyStimulus(1'b0, 1'b0);
         n++;
      end
      checkOutput("drain_bound", {31'd0, n < maxCycles}, 32'd1);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic pushRandom(input int n);
      for (int i = 0; i < n; i++) srcQ.push_back(DATA_W'($urandom_range(0, 63)));
   endtask

   initial begin
      RESET      = 1'b0;
      pause      = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = '0;
      mInflight  = 1'b0;
      mCnt       = 8'd0;
      #1;
      doReset();

      srcQ.push_back(6'b010010);
      drain(20);
      checkOutput("single_cnt", {24'd0, word_cnt}, 32'd1);
      checkOutput("single_data", {26'd0, data_out}, 32'b010010);

      srcQ.push_back(6'b100100);
      srcQ.push_back(6'b110110);
      srcQ.push_back(6'b010100);
      srcQ.push_back(6'b110000);
      srcQ.push_back(6'b110010);
      drain(30);
      checkOutput("five_cnt", {24'd0, word_cnt}, 32'd6);

      pushRandom(8);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
      drain(40);

      pushRandom(10);
      for (int i = 0; i < 30; i++) applyStimulus(1'b0, (i % 2) == 0);
      drain(40);

      pushRandom(40);
      for (int i = 0; i < 150; i++)
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      drain(100);

      pushRandom(6);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      doReset();
      drain(40);

      doReset();
      pushRandom(260);
      drain(600);
      checkOutput("wrap_cnt", {24'd0, word_cnt}, 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
